// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the RV32I multi-cycle sequencer and single-cycle decoder.
// Holds the state enum, opcode constants and the ALU/immediate/PC/writeback select codes.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_IMM, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_LUI, C_NONE
    } iclass_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_TARGET = 2'd1;
    localparam logic [1:0] PC_HOLD   = 2'd2;

    localparam logic [1:0] RD_ALU  = 2'd0;
    localparam logic [1:0] RD_DMEM = 2'd1;
    localparam logic [1:0] RD_PC4  = 2'd2;

    // Decode fields captured in DECODE and held until the next FETCH.
    typedef struct packed {
        iclass_t    cls;
        logic [3:0] alu_op;
        logic       alu_a_src;
        logic       alu_b_src;
        logic [2:0] imm_src;
        logic [1:0] ru_data_src;
        logic [2:0] funct3;
    } dec_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational opcode/funct3/funct7 to ALU operation decode.
// Flags unsupported opcodes and funct7 values that do not name an operation.
module alu_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_op,
    output logic       illegal
);

    logic is_r;
    assign is_r = (opcode == OP_R);

    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (opcode)
            OP_R, OP_IMM: begin
                case (funct3)
                    3'd0: begin
                        // Immediate form has no SUB; funct7 there is immediate bits.
                        if (!is_r || funct7 == 7'd0) alu_op = ALU_ADD;
                        else if (funct7 == 7'd32)    alu_op = ALU_SUB;
                        else                         illegal = 1'b1;
                    end
                    3'd1: begin
                        alu_op = ALU_SLL;
                        if (funct7 != 7'd0) illegal = 1'b1;
                    end
                    3'd5: begin
                        if (funct7 == 7'd0)       alu_op = ALU_SRL;
                        else if (funct7 == 7'd32) alu_op = ALU_SRA;
                        else                      illegal = 1'b1;
                    end
                    default: begin
                        case (funct3)
                            3'd2:    alu_op = ALU_SLT;
                            3'd3:    alu_op = ALU_SLTU;
                            3'd4:    alu_op = ALU_XOR;
                            3'd6:    alu_op = ALU_OR;
                            default: alu_op = ALU_AND;
                        endcase
                        if (is_r && funct7 != 7'd0) illegal = 1'b1;
                    end
                endcase
            end
            OP_LOAD, OP_STORE, OP_JAL, OP_LUI: alu_op = ALU_ADD;
            OP_BRANCH:                         alu_op = ALU_SUB;
            default:                           illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with memory handshakes.
// A wait counter halts the core with a sticky bus_error if a memory never answers.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       br_taken,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic [3:0] alu_op,
    output logic       alu_a_src,
    output logic       alu_b_src,
    output logic [2:0] imm_src,
    output logic       ru_wr,
    output logic [1:0] ru_data_src,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic [2:0] dm_ctrl,
    output logic       illegal_instr,
    output logic       bus_error,
    output logic       retire,
    output logic [2:0] state_o
);

    state_t           state, state_nx;
    dec_t             dec_q, dec_d;
    logic [CNT_W-1:0] wait_cnt;
    logic             berr_q;
    logic [3:0]       dec_alu_op;
    logic             dec_illegal;
    logic             wait_phase, ready_now, timeout;

    alu_decode u_alu_decode (
        .opcode  (opcode),
        .funct3  (funct3),
        .funct7  (funct7),
        .alu_op  (dec_alu_op),
        .illegal (dec_illegal)
    );

    always_comb begin
        dec_d        = '0;
        dec_d.cls    = C_NONE;
        dec_d.alu_op = dec_alu_op;
        dec_d.funct3 = funct3;
        case (opcode)
            OP_R:      dec_d.cls = C_R;
            OP_IMM:    begin dec_d.cls = C_IMM;   dec_d.alu_b_src = 1'b1; dec_d.imm_src = IMM_I; end
            OP_LOAD:   begin dec_d.cls = C_LOAD;  dec_d.alu_b_src = 1'b1; dec_d.imm_src = IMM_I;
                             dec_d.ru_data_src = RD_DMEM; end
            OP_STORE:  begin dec_d.cls = C_STORE; dec_d.alu_b_src = 1'b1; dec_d.imm_src = IMM_S; end
            OP_BRANCH: begin dec_d.cls = C_BRANCH; dec_d.imm_src = IMM_B; end
            OP_JAL:    begin dec_d.cls = C_JAL;   dec_d.alu_a_src = 1'b1; dec_d.alu_b_src = 1'b1;
                             dec_d.imm_src = IMM_J; dec_d.ru_data_src = RD_PC4; end
            OP_LUI:    begin dec_d.cls = C_LUI;   dec_d.alu_b_src = 1'b1; dec_d.imm_src = IMM_U; end
            default:   dec_d.cls = C_NONE;
        endcase
    end

    // A ready arriving on the limit cycle still completes the access.
    assign wait_phase = (state == S_FETCH) || (state == S_MEMORY);
    assign ready_now  = (state == S_FETCH) ? imem_ready : dmem_ready;
    assign timeout    = wait_phase && !ready_now && (wait_cnt == CNT_W'(WAIT_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            dec_q    <= '0;
            wait_cnt <= '0;
            berr_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_DECODE) dec_q <= dec_d;
            if (wait_phase && !ready_now && !timeout) wait_cnt <= wait_cnt + 1'b1;
            else                                      wait_cnt <= '0;
            if (timeout) berr_q <= 1'b1;
        end
    end

    always_comb begin
        state_nx      = state;
        imem_req      = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        pc_src        = PC_HOLD;
        alu_op        = ALU_AND;
        alu_a_src     = 1'b0;
        alu_b_src     = 1'b0;
        imm_src       = IMM_I;
        ru_wr         = 1'b0;
        ru_data_src   = RD_ALU;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        dm_ctrl       = 3'd0;
        illegal_instr = 1'b0;
        retire        = 1'b0;
        if (rst_n) begin
            if (state == S_EXECUTE || state == S_MEMORY || state == S_WRITEBACK) begin
                alu_op    = dec_q.alu_op;
                alu_a_src = dec_q.alu_a_src;
                alu_b_src = dec_q.alu_b_src;
                imm_src   = dec_q.imm_src;
            end
            case (state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_we    = 1'b1;
                        pc_we    = 1'b1;
                        pc_src   = PC_PLUS4;
                        state_nx = S_DECODE;
                    end else if (timeout) begin
                        state_nx = S_HALT;
                    end
                end
                S_DECODE: begin
                    if (dec_illegal) begin
                        illegal_instr = 1'b1;
                        state_nx      = S_FETCH;
                    end else begin
                        state_nx = S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    case (dec_q.cls)
                        C_R, C_IMM, C_LUI: state_nx = S_WRITEBACK;
                        C_LOAD, C_STORE:   state_nx = S_MEMORY;
                        C_BRANCH: begin
                            pc_we    = br_taken;
                            pc_src   = PC_TARGET;
                            retire   = 1'b1;
                            state_nx = S_FETCH;
                        end
                        C_JAL: begin
                            pc_we    = 1'b1;
                            pc_src   = PC_TARGET;
                            state_nx = S_WRITEBACK;
                        end
                        default: state_nx = S_FETCH;
                    endcase
                end
                S_MEMORY: begin
                    dmem_req = 1'b1;
                    dmem_we  = (dec_q.cls == C_STORE);
                    dm_ctrl  = dec_q.funct3;
                    if (dmem_ready) begin
                        if (dec_q.cls == C_STORE) begin
                            retire   = 1'b1;
                            state_nx = S_FETCH;
                        end else begin
                            state_nx = S_WRITEBACK;
                        end
                    end else if (timeout) begin
                        state_nx = S_HALT;
                    end
                end
                S_WRITEBACK: begin
                    ru_wr       = 1'b1;
                    retire      = 1'b1;
                    ru_data_src = dec_q.ru_data_src;
                    state_nx    = S_FETCH;
                end
                S_HALT:  state_nx = S_HALT;
                default: state_nx = S_FETCH;
            endcase
        end
    end

    assign bus_error = berr_q;
    assign state_o   = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected control vectors built
// from instruction-level rules, with randomized instructions and memory latencies.
module tb_multicycle_ctrl;

    localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LD_OP = 7'b0000011;
    localparam logic [6:0] ST_OP = 7'b0100011, BR_OP = 7'b1100011, JAL_OP = 7'b1101111;
    localparam logic [6:0] LUI_OP = 7'b0110111;

    typedef struct packed {
        logic       imem_req, ir_we, pc_we;
        logic [1:0] pc_src;
        logic [3:0] alu_op;
        logic       alu_a, alu_b;
        logic [2:0] imm;
        logic       ru_wr;
        logic [1:0] rds;
        logic       dmem_req, dmem_we;
        logic [2:0] dm;
        logic       ill, ret, berr;
        logic [2:0] st;
    } ov_t;
    localparam int W = $bits(ov_t);

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic       br_taken, imem_ready, dmem_ready;
    logic       imem_req, ir_we, pc_we, alu_a_src, alu_b_src, ru_wr, dmem_req, dmem_we;
    logic       illegal_instr, bus_error, retire;
    logic [1:0] pc_src, ru_data_src;
    logic [3:0] alu_op;
    logic [2:0] imm_src, dm_ctrl, state_o;
    ov_t        act;

    ov_t  exp_q[$];
    ov_t  msk_q[$];
    bit   imr_q[$];
    bit   dmr_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    multicycle_ctrl #(.WAIT_LIMIT(15), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .br_taken(br_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_op(alu_op), .alu_a_src(alu_a_src), .alu_b_src(alu_b_src), .imm_src(imm_src),
        .ru_wr(ru_wr), .ru_data_src(ru_data_src), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dm_ctrl(dm_ctrl), .illegal_instr(illegal_instr), .bus_error(bus_error),
        .retire(retire), .state_o(state_o)
    );

    assign act = {imem_req, ir_we, pc_we, pc_src, alu_op, alu_a_src, alu_b_src, imm_src,
                  ru_wr, ru_data_src, dmem_req, dmem_we, dm_ctrl, illegal_instr, retire,
                  bus_error, state_o};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    // Signals whose value is defined in every state.
    function automatic ov_t base_mask();
        ov_t m = '0;
        m.imem_req = 1'b1; m.ir_we = 1'b1; m.pc_we = 1'b1; m.ru_wr = 1'b1;
        m.dmem_req = 1'b1; m.dmem_we = 1'b1; m.ill = 1'b1; m.ret = 1'b1;
        m.berr = 1'b1; m.st = 3'b111;
        return m;
    endfunction

    function automatic ov_t reset_vec();
        ov_t e = '0;
        e.pc_src = 2'd2;
        return e;
    endfunction

    function automatic void ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [6:0] f7, output logic [3:0] aop,
                                       output bit ill);
        logic [3:0] base [8];
        base = '{4'd2, 4'd3, 4'd6, 4'd9, 4'd7, 4'd5, 4'd1, 4'd0};
        ill = 1'b0;
        aop = 4'd2;
        if (op == R_OP || op == I_OP) begin
            aop = base[f3];
            if (f3 == 3'd0) begin
                if (op == R_OP && f7 == 7'd32) aop = 4'd4;
                else if (op == R_OP && f7 != 7'd0) ill = 1'b1;
            end else if (f3 == 3'd5) begin
                if (f7 == 7'd32) aop = 4'd13;
                else if (f7 != 7'd0) ill = 1'b1;
            end else if (f3 == 3'd1 || op == R_OP) begin
                if (f7 != 7'd0) ill = 1'b1;
            end
        end else if (op == BR_OP) begin
            aop = 4'd4;
        end else if (op != LD_OP && op != ST_OP && op != JAL_OP && op != LUI_OP) begin
            ill = 1'b1;
        end
    endfunction

    task automatic push(input ov_t e, input ov_t m, input bit imr, input bit dmr);
        exp_q.push_back(e); msk_q.push_back(m); imr_q.push_back(imr); dmr_q.push_back(dmr);
    endtask

    task automatic push_fetch(input int lat);
        ov_t e, m;
        for (int i = 0; i < lat; i++) begin
            e = '0; e.imem_req = 1'b1;
            push(e, base_mask(), 1'b0, 1'b0);
        end
        e = '0; e.imem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1; e.pc_src = 2'd0;
        m = base_mask(); m.pc_src = 2'b11;
        push(e, m, 1'b1, 1'b0);
    endtask

    task automatic build_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input bit br, input int il, input int dl);
        ov_t        e, m;
        logic [3:0] aop;
        bit         ill;
        ref_decode(op, f3, f7, aop, ill);
        push_fetch(il);
        e = '0; e.st = 3'd1; e.ill = ill;
        push(e, base_mask(), 1'b0, 1'b0);
        if (ill) return;
        e = '0; e.st = 3'd2; e.alu_op = aop;
        m = base_mask(); m.alu_op = 4'hf; m.alu_b = 1'b1;
        if (op != R_OP) m.imm = 3'b111;
        case (op)
            I_OP, LD_OP: begin e.alu_b = 1'b1; e.imm = 3'd0; end
            ST_OP:       begin e.alu_b = 1'b1; e.imm = 3'd1; end
            BR_OP:       begin e.imm = 3'd2; e.pc_we = br; e.pc_src = 2'd1; e.ret = 1'b1;
                               m.pc_src = 2'b11; end
            JAL_OP:      begin e.alu_b = 1'b1; e.imm = 3'd4; e.pc_we = 1'b1; e.pc_src = 2'd1;
                               m.pc_src = 2'b11; end
            LUI_OP:      begin e.alu_b = 1'b1; e.imm = 3'd3; m.alu_a = 1'b1; end
            default:     ;
        endcase
        push(e, m, 1'b0, 1'b0);
        if (op == BR_OP) return;
        if (op == LD_OP || op == ST_OP) begin
            e = '0; e.st = 3'd3; e.dmem_req = 1'b1; e.dmem_we = (op == ST_OP); e.dm = f3;
            m = base_mask(); m.dm = 3'b111;
            for (int i = 0; i < dl; i++) push(e, m, 1'b0, 1'b0);
            e.ret = (op == ST_OP);
            push(e, m, 1'b0, 1'b1);
            if (op == ST_OP) return;
        end
        e = '0; e.st = 3'd4; e.ru_wr = 1'b1; e.ret = 1'b1;
        e.rds = (op == LD_OP) ? 2'd1 : (op == JAL_OP) ? 2'd2 : 2'd0;
        m = base_mask(); m.rds = 2'b11;
        push(e, m, 1'b0, 1'b0);
    endtask

    // Entered and left at a falling edge; inputs change there, outputs sampled 2ns later.
    task automatic run_queue(input string tag, input int limit);
        ov_t            e, m;
        logic [W-1:0]   a_v, e_v, m_v;
        int             n = 0;
        while (exp_q.size() > 0 && n < limit) begin
            e = exp_q.pop_front(); m = msk_q.pop_front();
            imem_ready = imr_q.pop_front(); dmem_ready = dmr_q.pop_front();
            #2;
            a_v = act; e_v = e; m_v = m;
            check($sformatf("%s_c%0d", tag, n), a_v & m_v, e_v & m_v);
            @(negedge clk);
            n++;
        end
        exp_q.delete(); msk_q.delete(); imr_q.delete(); dmr_q.delete();
        imem_ready = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input bit br, input int il, input int dl);
        opcode = op; funct3 = f3; funct7 = f7; br_taken = br;
        build_instr(op, f3, f7, br, il, dl);
        run_queue(tag, 1000);
    endtask

    task automatic rand_instr(output logic [6:0] op, output logic [2:0] f3, output logic [6:0] f7);
        int k = $urandom_range(0, 7);
        f3 = 3'($urandom_range(0, 7));
        f7 = 7'($urandom_range(0, 127));
        case (k)
            0: begin
                op = R_OP;
                if (f3 == 3'd0) begin
                    case ($urandom_range(0, 2))
                        0:       f7 = 7'd0;
                        1:       f7 = 7'd32;
                        default: f7 = 7'($urandom_range(1, 31));
                    endcase
                end else if (f3 == 3'd5) f7 = $urandom_range(0, 1) ? 7'd32 : 7'd0;
                else f7 = 7'd0;
            end
            1: begin
                op = I_OP;
                if (f3 == 3'd1) f7 = 7'd0;
                else if (f3 == 3'd5) f7 = $urandom_range(0, 1) ? 7'd32 : 7'd0;
            end
            2: op = LD_OP;
            3: begin op = ST_OP; f3 = 3'($urandom_range(0, 2)); end
            4: op = BR_OP;
            5: op = JAL_OP;
            6: op = LUI_OP;
            default: begin
                op = 7'($urandom_range(0, 127));
                while (op == R_OP || op == I_OP || op == LD_OP || op == ST_OP ||
                       op == BR_OP || op == JAL_OP || op == LUI_OP)
                    op = 7'($urandom_range(0, 127));
            end
        endcase
    endtask

    initial begin
        logic [6:0] op, f7;
        logic [2:0] f3;
        ov_t        e;
        rst_n = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
        br_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2 check("reset", act, reset_vec());
        @(negedge clk);
        rst_n = 1'b1;

        run_instr("add",    R_OP,  3'd0, 7'd0,  1'b0, 2, 0);
        run_instr("sub",    R_OP,  3'd0, 7'd32, 1'b0, 0, 0);
        run_instr("sra",    R_OP,  3'd5, 7'd32, 1'b0, 1, 0);
        run_instr("r_f7_1", R_OP,  3'd0, 7'd1,  1'b0, 0, 0);
        run_instr("load",   LD_OP, 3'd2, 7'd5,  1'b0, 0, 4);
        run_instr("br_nt",  BR_OP, 3'd0, 7'd0,  1'b0, 1, 0);
        run_instr("br_t",   BR_OP, 3'd1, 7'd0,  1'b1, 0, 0);
        run_instr("store",  ST_OP, 3'd1, 7'd0,  1'b0, 0, 0);
        run_instr("jal",    JAL_OP, 3'd3, 7'd9, 1'b0, 0, 0);
        run_instr("lui",    LUI_OP, 3'd7, 7'd3, 1'b0, 0, 0);
        run_instr("addi",   I_OP,  3'd0, 7'd32, 1'b0, 0, 0);
        run_instr("badop",  7'h7f, 3'd0, 7'd0,  1'b0, 0, 0);
        run_instr("imlim",  R_OP,  3'd6, 7'd0,  1'b0, 15, 0);
        run_instr("dmlim",  LD_OP, 3'd4, 7'd0,  1'b0, 0, 15);

        for (int i = 0; i < 40; i++) begin
            rand_instr(op, f3, f7);
            run_instr($sformatf("rnd%0d", i), op, f3, f7, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 4), $urandom_range(0, 5));
        end

        // Instruction memory never answers: 16 FETCH cycles, then sticky HALT.
        opcode = R_OP; funct3 = 3'd0; funct7 = 7'd0;
        for (int i = 0; i < 16; i++) begin
            e = '0; e.imem_req = 1'b1;
            push(e, base_mask(), 1'b0, 1'b0);
        end
        e = '0; e.st = 3'd7; e.berr = 1'b1;
        for (int i = 0; i < 3; i++) push(e, base_mask(), 1'b1, 1'b1);
        run_queue("hang", 1000);
        rst_n = 1'b0;
        #2 check("halt_rst", act, reset_vec());
        @(negedge clk);
        rst_n = 1'b1;
        run_instr("after_halt", R_OP, 3'd4, 7'd0, 1'b0, 1, 0);

        // Reset lands while a STORE is waiting in MEMORY.
        opcode = ST_OP; funct3 = 3'd2; funct7 = 7'd0; br_taken = 1'b0;
        build_instr(ST_OP, 3'd2, 7'd0, 1'b0, 1, 10);
        run_queue("st_pre", 6);
        rst_n = 1'b0;
        #2 check("st_rst", act, reset_vec());
        @(negedge clk);
        rst_n = 1'b1;
        #2 begin
            logic [W-1:0] a_v, e_v, m_v;
            e = '0; e.imem_req = 1'b1;
            a_v = act; e_v = e; m_v = base_mask();
            check("st_post", a_v & m_v, e_v & m_v);
        end
        @(negedge clk);
        run_instr("after_st", LD_OP, 3'd0, 7'd0, 1'b0, 1, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
